// File: rtl/eth_types_pkg.sv
// Shared types and constants for the Ethernet/IPv4/UDP receive path.
package eth_types_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    TRAILER,
    DROP
  } eth_rx_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hC704DD7B;
  localparam int unsigned ETH_HDR_LEN    = 14;
  localparam int unsigned UDP_HDR_LEN    = 8;

  // 16-bit ones'-complement add with end-around carry
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise Ethernet CRC-32. The register runs LSB-first (reflected); the
// crc port presents it bit-reversed so it compares against the normal-order residue.
module eth_crc32
  import eth_types_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

  logic [31:0] c_q;
  logic [31:0] c_n;

  // one byte of reflected CRC update, LSB of din first
  always_comb begin
    c_n = c_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c_n[0] ^ din[i]) c_n = (c_n >> 1) ^ POLY_REFL;
      else                 c_n = c_n >> 1;
    end
  end

  // CRC register, seeded with all ones
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   c_q <= '1;
    else if (init) c_q <= '1;
    else if (en)   c_q <= c_n;
  end

  assign crc = bitrev32(c_q);

endmodule

// File: rtl/eth_udp_rx.sv
// Ethernet/IPv4/UDP receive parser: filters on MAC/IP/port, checks the IP
// header checksum and FCS, streams payload and reports a per-frame verdict.
module eth_udp_rx
  import eth_types_pkg::*;
#(
  parameter logic [47:0]            FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0]            FPGA_IP      = 32'hC0_00_02_92,
  parameter int unsigned            NUM_PORTS    = 2,
  parameter logic [NUM_PORTS*16-1:0] PORT_LIST   = {16'd5006, 16'd5005},
  parameter logic                   ACCEPT_BCAST = 1'b1,
  localparam int unsigned           PIW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [7:0]     rx_byte,
  input  logic           rx_valid,
  input  logic           rx_active,
  output logic [7:0]     data,
  output logic           data_valid,
  output logic           data_last,
  output logic [PIW-1:0] data_port,
  output logic           frame_done,
  output logic           frame_ok,
  output logic [15:0]    drop_cnt
);

  eth_rx_state_t state, state_n;

  logic           act_q, bv, rise, fall;
  logic [15:0]    byte_cnt, word;
  logic [7:0]     prev_byte, addr_exp;
  logic [3:0]     ihl;
  logic [15:0]    hdr_len, ip_total, udp_len, csum, csum_next, pl_last_cnt;
  logic           uc_miss, bc_miss, addr_byte, addr_ok;
  logic           port_hit, udp_len_ok, any_pl;
  logic [PIW-1:0] port_sel;
  logic [31:0]    crc_val;
  logic           crc_good;
  logic           pl_valid_n, pl_last_n, done_n, ok_n, drop_inc;

  // act_q resets high so a frame already in flight at reset release is ignored
  // until rx_active has been seen low
  assign bv          = rx_valid & rx_active;
  assign rise        = rx_active & ~act_q;
  assign fall        = ~rx_active & act_q;
  assign word        = {prev_byte, rx_byte};
  assign hdr_len     = {10'd0, ihl, 2'b00};
  assign csum_next   = csum_add(csum, word);
  assign pl_last_cnt = udp_len - 16'(UDP_HDR_LEN + 1);
  assign crc_good    = (crc_val == CRC32_RESIDUE);
  assign udp_len_ok  = (word >= 16'(UDP_HDR_LEN)) &&
                       (({1'b0, word} + {1'b0, hdr_len}) <= {1'b0, ip_total});
  assign addr_byte   = bv && ((state == ETH_HDR && byte_cnt < 16'd6) ||
                              (state == IP_HDR && byte_cnt >= 16'd16 && byte_cnt < 16'd20));
  assign addr_ok     = (!uc_miss && rx_byte == addr_exp) ||
                       (ACCEPT_BCAST && !bc_miss && rx_byte == 8'hFF);

  eth_crc32 u_crc (
    .clk    (clk),
    .resetn (resetn),
    .init   (state == IDLE),
    .en     (bv && state != IDLE),
    .din    (rx_byte),
    .crc    (crc_val)
  );

  // expected unicast address byte for the current MAC / IP position
  always_comb begin
    addr_exp = '0;
    for (int unsigned i = 0; i < 6; i++)
      if (state == ETH_HDR && byte_cnt == 16'(i)) addr_exp = FPGA_MAC[8*(5-i) +: 8];
    for (int unsigned i = 0; i < 4; i++)
      if (state == IP_HDR && byte_cnt == 16'(16 + i)) addr_exp = FPGA_IP[8*(3-i) +: 8];
  end

  // lowest-index matching UDP port
  always_comb begin
    port_hit = 1'b0;
    port_sel = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      if (!port_hit && word == PORT_LIST[16*i +: 16]) begin
        port_hit = 1'b1;
        port_sel = PIW'(i);
      end
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // next-state: frame end wins, otherwise per-byte header checks
  always_comb begin
    state_n = state;
    if (state != IDLE && fall) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (rise) state_n = ETH_HDR;
        ETH_HDR: if (bv) begin
          if (byte_cnt == 16'd5 && !addr_ok) state_n = DROP;
          else if (byte_cnt == 16'(ETH_HDR_LEN - 1))
            state_n = (word == ETHERTYPE_IPV4) ? IP_HDR : DROP;
        end
        IP_HDR: if (bv) begin
          if (byte_cnt == 16'd0 && (rx_byte[7:4] != 4'd4 || rx_byte[3:0] < 4'd5)) state_n = DROP;
          else if (byte_cnt == 16'd7 && (prev_byte[5] || word[12:0] != 13'd0))   state_n = DROP;
          else if (byte_cnt == 16'd9 && rx_byte != IP_PROTO_UDP)                  state_n = DROP;
          else if (byte_cnt == 16'd19 && !addr_ok)                                state_n = DROP;
          else if (byte_cnt == hdr_len - 16'd1)
            state_n = (csum_next == 16'hFFFF) ? UDP_HDR : DROP;
        end
        UDP_HDR: if (bv) begin
          if (byte_cnt == 16'd3 && !port_hit)        state_n = DROP;
          else if (byte_cnt == 16'd5 && !udp_len_ok) state_n = DROP;
          else if (byte_cnt == 16'(UDP_HDR_LEN - 1))
            state_n = (udp_len == 16'(UDP_HDR_LEN)) ? TRAILER : PAYLOAD;
        end
        PAYLOAD: if (bv && byte_cnt == pl_last_cnt) state_n = TRAILER;
        default: state_n = state;
      endcase
    end
  end

  // output decode: payload strobes and end-of-frame verdict
  always_comb begin
    pl_valid_n = (state == PAYLOAD) && bv;
    pl_last_n  = pl_valid_n && (byte_cnt == pl_last_cnt);
    done_n     = 1'b0;
    ok_n       = 1'b0;
    drop_inc   = 1'b0;
    if (state != IDLE && fall) begin
      drop_inc = (state != TRAILER) || !crc_good;
      if (state == TRAILER) begin
        done_n = 1'b1;
        ok_n   = crc_good;
      end else if (state == PAYLOAD && any_pl) begin
        done_n = 1'b1;
      end
    end
  end

  // header field capture, byte counter and checksum accumulator
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_q     <= 1'b1;
      byte_cnt  <= '0;
      prev_byte <= '0;
      ihl       <= '0;
      ip_total  <= '0;
      udp_len   <= '0;
      csum      <= '0;
      uc_miss   <= 1'b0;
      bc_miss   <= 1'b0;
      any_pl    <= 1'b0;
    end else begin
      act_q <= rx_active;
      if (bv) prev_byte <= rx_byte;
      if (state_n != state)             byte_cnt <= '0;
      else if (bv && state != IDLE)     byte_cnt <= byte_cnt + 16'd1;
      if (state_n != state) begin
        uc_miss <= 1'b0;
        bc_miss <= 1'b0;
      end else if (addr_byte) begin
        uc_miss <= uc_miss | (rx_byte != addr_exp);
        bc_miss <= bc_miss | (rx_byte != 8'hFF);
      end
      if (state_n != state) csum <= '0;
      else if (state == IP_HDR && bv && byte_cnt[0]) csum <= csum_next;
      if (state == IP_HDR && bv && byte_cnt == 16'd0)  ihl      <= rx_byte[3:0];
      if (state == IP_HDR && bv && byte_cnt == 16'd3)  ip_total <= word;
      if (state == UDP_HDR && bv && byte_cnt == 16'd5) udp_len  <= word;
      if (state == IDLE)    any_pl <= 1'b0;
      else if (pl_valid_n)  any_pl <= 1'b1;
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data       <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      data_port  <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      data_valid <= pl_valid_n;
      data_last  <= pl_last_n;
      if (pl_valid_n) data <= rx_byte;
      if (state == UDP_HDR && bv && byte_cnt == 16'd3 && port_hit) data_port <= port_sel;
      frame_done <= done_n;
      frame_ok   <= ok_n;
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_udp_rx.sv
// Scoreboard bench for eth_udp_rx: frames are built with independent IP
// checksum and FCS generation; expected payload and verdicts are queued.
module tb_eth_udp_rx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_active = 1'b0;
  logic [7:0]  data;
  logic        data_valid, data_last;
  logic [0:0]  data_port;
  logic        frame_done, frame_ok;
  logic [15:0] drop_cnt;

  localparam logic [47:0] MAC  = 48'h001A2B3C4D5E;
  localparam logic [31:0] IP   = 32'hC0000292;
  localparam logic [47:0] BMAC = 48'hFFFFFFFFFFFF;
  localparam logic [31:0] BIP  = 32'hFFFFFFFF;

  always #10 clk = ~clk;

  eth_udp_rx dut (
    .clk(clk), .resetn(resetn), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_active(rx_active), .data(data), .data_valid(data_valid),
    .data_last(data_last), .data_port(data_port), .frame_done(frame_done),
    .frame_ok(frame_ok), .drop_cnt(drop_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_drop = '0;
  logic [7:0]  tx[$];
  logic [9:0]  exp_pl[$], obs_pl[$];   // {last, port, byte}
  logic        exp_fd[$], obs_fd[$];   // frame_ok per frame_done
  logic [9:0]  e, o;
  logic        ef, of;

  always @(negedge clk) begin
    if (data_valid) obs_pl.push_back({data_last, data_port, data});
    if (frame_done) obs_fd.push_back(frame_ok);
  end

  function automatic logic [31:0] calc_fcs();
    logic [31:0] c;
    c = '1;
    foreach (tx[i]) begin
      c = c ^ {24'd0, tx[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [47:0] mac, input logic [15:0] etype,
                             input logic [31:0] ip, input logic [15:0] cs_err,
                             input logic [15:0] port, input int ihl, input int plen,
                             input logic [7:0] base, input logic [31:0] fcs_xor);
    logic [7:0]  h[60];
    logic [31:0] s, fcs;
    logic [15:0] total, ulen, cs;
    tx.delete();
    for (int i = 5; i >= 0; i--) tx.push_back(mac[8*i +: 8]);
    tx.push_back(8'h02); for (int i = 0; i < 4; i++) tx.push_back(8'h00); tx.push_back(8'h01);
    tx.push_back(etype[15:8]); tx.push_back(etype[7:0]);
    total = 16'(ihl * 4 + 8 + plen);
    ulen  = 16'(8 + plen);
    for (int i = 0; i < 60; i++) h[i] = 8'h00;
    h[0] = 8'h40 | 8'(ihl); h[2] = total[15:8]; h[3] = total[7:0];
    h[4] = 8'h12; h[5] = 8'h34; h[6] = 8'h40; h[8] = 8'd64; h[9] = 8'd17;
    h[12] = 8'hC0; h[13] = 8'h00; h[14] = 8'h02; h[15] = 8'h01;
    h[16] = ip[31:24]; h[17] = ip[23:16]; h[18] = ip[15:8]; h[19] = ip[7:0];
    s = 0;
    for (int w = 0; w < ihl * 2; w++) s = s + {16'd0, h[2*w], h[2*w+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0] + cs_err;
    h[10] = cs[15:8]; h[11] = cs[7:0];
    for (int i = 0; i < ihl * 4; i++) tx.push_back(h[i]);
    tx.push_back(8'h04); tx.push_back(8'hD2); tx.push_back(port[15:8]); tx.push_back(port[7:0]);
    tx.push_back(ulen[15:8]); tx.push_back(ulen[7:0]); tx.push_back(8'h00); tx.push_back(8'h00);
    for (int k = 0; k < plen; k++) tx.push_back(base + 8'(k));
    while (tx.size() < 60) tx.push_back(8'h00);
    fcs = calc_fcs() ^ fcs_xor;
    for (int i = 0; i < 4; i++) tx.push_back(fcs[8*i +: 8]);
  endtask

  task automatic push_exp(input int n, input logic [7:0] base, input logic port, input logic with_last);
    for (int k = 0; k < n; k++)
      exp_pl.push_back({with_last && (k == n - 1), port, base + 8'(k)});
  endtask

  // a stray strobe with rx_active low precedes every frame and must be ignored
  task automatic frame_start();
    @(negedge clk); rx_byte = 8'h55; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rx_active = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      rx_byte = tx[i]; rx_valid = 1'b1;
      @(negedge clk); rx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic frame_end();
    rx_active = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({data, data_valid, data_last, data_port, frame_done, frame_ok, drop_cnt} !== 29'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0",
        {data, data_valid, data_last, data_port, frame_done, frame_ok, drop_cnt});
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fcs();
    for (int k = 0; k < 2; k++) begin
      build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5005, 5, 18, 8'h00, (k == 1) ? 32'h1 : 32'h0);
      push_exp(18, 8'h00, 1'b0, 1'b1);
      exp_fd.push_back(k == 0);
      if (k == 1) exp_drop++;
      frame_start(); send_bytes(0, tx.size()); frame_end();
      n_cmp++;
      if (obs_pl.size() != exp_pl.size()) begin
        n_err++; $display("FAIL fcs%0d_strobes: got %0d want %0d", k, obs_pl.size(), exp_pl.size());
      end
      while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
        e = exp_pl.pop_front(); o = obs_pl.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL fcs%0d_byte: got %h want %h", k, o, e); end
      end
      n_cmp++;
      if (obs_fd.size() != exp_fd.size()) begin
        n_err++; $display("FAIL fcs%0d_done: got %0d want %0d", k, obs_fd.size(), exp_fd.size());
      end
      while (exp_fd.size() > 0 && obs_fd.size() > 0) begin
        ef = exp_fd.pop_front(); of = obs_fd.pop_front(); n_cmp++;
        if (of !== ef) begin n_err++; $display("FAIL fcs%0d_ok: got %b want %b", k, of, ef); end
      end
      n_cmp++;
      if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL fcs%0d_drop: got %0d want %0d", k, drop_cnt, exp_drop); end
      exp_pl.delete(); obs_pl.delete(); exp_fd.delete(); obs_fd.delete();
    end
  endtask

  task automatic test_filters();
    for (int k = 0; k < 4; k++) begin
      build_frame((k == 0) ? 48'h001A2B3C4D5F : MAC, (k == 3) ? 16'h0806 : 16'h0800, IP,
                  (k == 1) ? 16'd1 : 16'd0, (k == 2) ? 16'd6000 : 16'd5005, 5, 18, 8'h00, 32'h0);
      exp_drop++;
      frame_start(); send_bytes(0, tx.size()); frame_end();
      n_cmp++;
      if (obs_pl.size() != 0 || obs_fd.size() != 0) begin
        n_err++; $display("FAIL filter%0d_output: got %0d strobes %0d done want 0 0", k, obs_pl.size(), obs_fd.size());
      end
      n_cmp++;
      if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL filter%0d_drop: got %0d want %0d", k, drop_cnt, exp_drop); end
      obs_pl.delete(); obs_fd.delete();
    end
  endtask

  task automatic test_bcast_options();
    build_frame(BMAC, 16'h0800, BIP, 16'd0, 16'd5006, 6, 1, 8'hA5, 32'h0);
    push_exp(1, 8'hA5, 1'b1, 1'b1);
    exp_fd.push_back(1'b1);
    frame_start(); send_bytes(0, tx.size()); frame_end();
    n_cmp++;
    if (obs_pl.size() != 1) begin n_err++; $display("FAIL bcast_strobes: got %0d want 1", obs_pl.size()); end
    while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
      e = exp_pl.pop_front(); o = obs_pl.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL bcast_byte: got %h want %h", o, e); end
    end
    n_cmp++;
    if (obs_fd.size() != 1 || obs_fd[0] !== 1'b1) begin
      n_err++; $display("FAIL bcast_done: got %0d done want 1 with ok", obs_fd.size());
    end
    n_cmp++;
    if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL bcast_drop: got %0d want %0d", drop_cnt, exp_drop); end
    exp_pl.delete(); obs_pl.delete(); exp_fd.delete(); obs_fd.delete();
  endtask

  task automatic test_zero_payload();
    build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5005, 5, 0, 8'h00, 32'h0);
    frame_start(); send_bytes(0, tx.size()); frame_end();
    n_cmp++;
    if (obs_pl.size() != 0) begin n_err++; $display("FAIL zero_strobes: got %0d want 0", obs_pl.size()); end
    n_cmp++;
    if (obs_fd.size() != 1 || obs_fd[0] !== 1'b1) begin
      n_err++; $display("FAIL zero_done: got %0d done want 1 with ok", obs_fd.size());
    end
    n_cmp++;
    if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL zero_drop: got %0d want %0d", drop_cnt, exp_drop); end
    obs_pl.delete(); obs_fd.delete();
  endtask

  task automatic test_truncated();
    build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5005, 5, 18, 8'h00, 32'h0);
    push_exp(5, 8'h00, 1'b0, 1'b0);
    exp_drop++;
    frame_start(); send_bytes(0, 14 + 20 + 8 + 5); frame_end();
    n_cmp++;
    if (obs_pl.size() != 5) begin n_err++; $display("FAIL trunc_strobes: got %0d want 5", obs_pl.size()); end
    while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
      e = exp_pl.pop_front(); o = obs_pl.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL trunc_byte: got %h want %h", o, e); end
    end
    n_cmp++;
    if (obs_fd.size() != 1 || obs_fd[0] !== 1'b0) begin
      n_err++; $display("FAIL trunc_done: got %0d done want 1 with not-ok", obs_fd.size());
    end
    n_cmp++;
    if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL trunc_drop: got %0d want %0d", drop_cnt, exp_drop); end
    exp_pl.delete(); obs_pl.delete(); obs_fd.delete();
  endtask

  task automatic test_back_to_back();
    build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5006, 5, 3, 8'h80, 32'h0);
    push_exp(3, 8'h80, 1'b1, 1'b1);
    frame_start(); send_bytes(0, tx.size()); rx_active = 1'b0;
    build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5005, 5, 2, 8'h90, 32'h0);
    push_exp(2, 8'h90, 1'b0, 1'b1);
    frame_start(); send_bytes(0, tx.size()); frame_end();
    n_cmp++;
    if (obs_pl.size() != exp_pl.size()) begin
      n_err++; $display("FAIL b2b_strobes: got %0d want %0d", obs_pl.size(), exp_pl.size());
    end
    while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
      e = exp_pl.pop_front(); o = obs_pl.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b2b_byte: got %h want %h", o, e); end
    end
    n_cmp++;
    if (obs_fd.size() != 2 || obs_fd[0] !== 1'b1 || obs_fd[1] !== 1'b1) begin
      n_err++; $display("FAIL b2b_done: got %0d done want 2 with ok", obs_fd.size());
    end
    n_cmp++;
    if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL b2b_drop: got %0d want %0d", drop_cnt, exp_drop); end
    exp_pl.delete(); obs_pl.delete(); obs_fd.delete();
  endtask

  task automatic test_reset_mid_frame();
    build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5005, 5, 18, 8'h00, 32'h0);
    push_exp(3, 8'h00, 1'b0, 1'b0);
    frame_start(); send_bytes(0, 14 + 20 + 8 + 3);
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({data, data_valid, data_last, data_port, frame_done, frame_ok, drop_cnt} !== 29'd0) begin
      n_err++; $display("FAIL midreset_outputs: got %h want 0",
        {data, data_valid, data_last, data_port, frame_done, frame_ok, drop_cnt});
    end
    exp_drop = '0;
    @(negedge clk); resetn = 1'b1; @(negedge clk);
    send_bytes(14 + 20 + 8 + 4, tx.size()); frame_end();
    n_cmp++;
    if (obs_pl.size() != 3 || obs_fd.size() != 0) begin
      n_err++; $display("FAIL midreset_tail: got %0d strobes %0d done want 3 0", obs_pl.size(), obs_fd.size());
    end
    while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
      e = exp_pl.pop_front(); o = obs_pl.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL midreset_byte: got %h want %h", o, e); end
    end
    exp_pl.delete(); obs_pl.delete(); obs_fd.delete();
    build_frame(MAC, 16'h0800, IP, 16'd0, 16'd5006, 5, 4, 8'h40, 32'h0);
    push_exp(4, 8'h40, 1'b1, 1'b1);
    frame_start(); send_bytes(0, tx.size()); frame_end();
    n_cmp++;
    if (obs_pl.size() != 4) begin n_err++; $display("FAIL postreset_strobes: got %0d want 4", obs_pl.size()); end
    while (exp_pl.size() > 0 && obs_pl.size() > 0) begin
      e = exp_pl.pop_front(); o = obs_pl.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL postreset_byte: got %h want %h", o, e); end
    end
    n_cmp++;
    if (obs_fd.size() != 1 || obs_fd[0] !== 1'b1) begin
      n_err++; $display("FAIL postreset_done: got %0d done want 1 with ok", obs_fd.size());
    end
    n_cmp++;
    if (drop_cnt !== exp_drop) begin n_err++; $display("FAIL postreset_drop: got %0d want %0d", drop_cnt, exp_drop); end
    exp_pl.delete(); obs_pl.delete(); obs_fd.delete();
  endtask

  initial begin
    test_reset();
    test_fcs();
    test_filters();
    test_bcast_options();
    test_zero_payload();
    test_truncated();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
